// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - input FIFO plus per-lane skew chain feeding a systolic array's left edge.
module systolic_skew_feeder #(
    parameter int ROWS  = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        k_len_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [8*ROWS-1:0] in_data_i,
    output logic [8*ROWS-1:0] out_data_o,
    output logic [ROWS-1:0]   out_valid_o,
    output logic              pe_enable_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [7:0]        k_len_q;
    logic [7:0]        fed_q;
    logic [DW-1:0]     drain_q;

    logic [8*ROWS-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              push;
    logic              pop;
    logic [8*ROWS-1:0] pop_data;

    // Occupancy is registered, so a vector written this cycle cannot be popped until the next.
    assign in_ready_o = (count_q != FULL_CNT);
    assign push       = in_valid_i && in_ready_o;
    assign pop        = (state_q == S_FEED) && (count_q != '0) && (fed_q < k_len_q);
    assign pop_data   = mem_q[rd_ptr_q];

    assign pe_enable_o = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_len_q <= '0;
            fed_q   <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        k_len_q <= k_len_i;
                        fed_q   <= '0;
                        drain_q <= '0;
                        state_q <= (k_len_i == 8'd0) ? S_DONE : S_FEED;
                    end
                end
                S_FEED: begin
                    if (pop) begin
                        fed_q <= fed_q + 8'd1;
                        if (fed_q + 8'd1 == k_len_q) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == LAST_DRAIN) begin
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Lane i is i+1 registers deep; non-pop cycles shift zero bubbles so idle PEs accumulate nothing.
    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        logic [7:0] d_q [0:i];
        logic       v_q [0:i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) begin
                    d_q[s] <= 8'h00;
                    v_q[s] <= 1'b0;
                end
            end else begin
                d_q[0] <= pop ? pop_data[8*i +: 8] : 8'h00;
                v_q[0] <= pop;
                for (int s = 1; s <= i; s++) begin
                    d_q[s] <= d_q[s-1];
                    v_q[s] <= v_q[s-1];
                end
            end
        end

        assign out_data_o[8*i +: 8] = d_q[i];
        assign out_valid_o[i]       = v_q[i];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - randomized and directed bench for systolic_skew_feeder against a tile-level model.
module tb_systolic_skew_feeder;

    localparam int ROWS  = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [7:0]        k_len_i = 8'd0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [8*ROWS-1:0] in_data_i = '0;
    logic [8*ROWS-1:0] out_data_o;
    logic [ROWS-1:0]   out_valid_o;
    logic              pe_enable_o;
    logic              busy_o;
    logic              done_o;

    systolic_skew_feeder #(.ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .k_len_i     (k_len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .pe_enable_o (pe_enable_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum {M_IDLE, M_FEED, M_DRAIN, M_DONE} mode_t;
    mode_t             mode = M_IDLE;
    int                fed = 0;
    int                klen = 0;
    int                drain_left = 0;
    int                cyc = 0;
    logic [8*ROWS-1:0] fifo_q [$];
    logic [8*ROWS-1:0] popped [int];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [8*ROWS-1:0] exp_d;
        logic [ROWS-1:0]   exp_v;
        logic [8*ROWS-1:0] vec;
        exp_d = '0;
        exp_v = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (popped.exists(cyc - 1 - i)) begin
                vec = popped[cyc - 1 - i];
                exp_d[8*i +: 8] = vec[8*i +: 8];
                exp_v[i] = 1'b1;
            end
        end
        check_eq("out_data",  out_data_o,  exp_d);
        check_eq("out_valid", {28'd0, out_valid_o}, {28'd0, exp_v});
        check_eq("in_ready",  {31'd0, in_ready_o},  {31'd0, fifo_q.size() < DEPTH});
        check_eq("pe_enable", {31'd0, pe_enable_o}, {31'd0, mode == M_FEED || mode == M_DRAIN});
        check_eq("busy",      {31'd0, busy_o},      {31'd0, mode != M_IDLE});
        check_eq("done",      {31'd0, done_o},      {31'd0, mode == M_DONE});
    endtask

    task automatic check_reset_values();
        check_eq("rst_in_ready",  {31'd0, in_ready_o},  32'd1);
        check_eq("rst_out_data",  out_data_o,           32'd0);
        check_eq("rst_out_valid", {28'd0, out_valid_o}, 32'd0);
        check_eq("rst_pe_enable", {31'd0, pe_enable_o}, 32'd0);
        check_eq("rst_busy",      {31'd0, busy_o},      32'd0);
        check_eq("rst_done",      {31'd0, done_o},      32'd0);
    endtask

    // One clock edge of the tile rules, applied to the model with the inputs seen at that edge.
    task automatic model_advance(input logic st, input logic [7:0] k, input logic v, input logic [8*ROWS-1:0] d);
        bit do_pop;
        bit do_push;
        do_pop  = (mode == M_FEED) && (fifo_q.size() > 0) && (fed < klen);
        do_push = v && (fifo_q.size() < DEPTH);
        if (do_pop) popped[cyc] = fifo_q.pop_front();
        if (do_push) fifo_q.push_back(d);
        case (mode)
            M_IDLE: if (st) begin
                klen = int'(k);
                fed = 0;
                drain_left = ROWS;
                mode = (k == 8'd0) ? M_DONE : M_FEED;
            end
            M_FEED: if (do_pop) begin
                fed++;
                if (fed == klen) mode = M_DRAIN;
            end
            M_DRAIN: begin
                drain_left--;
                if (drain_left == 0) mode = M_DONE;
            end
            default: mode = M_IDLE;
        endcase
        cyc++;
    endtask

    task automatic model_reset();
        fifo_q.delete();
        popped.delete();
        mode = M_IDLE;
        fed = 0;
        klen = 0;
    endtask

    task automatic step(input logic st, input logic [7:0] k, input logic v, input logic [8*ROWS-1:0] d);
        @(negedge clk);
        check_outputs();
        start_i = st;
        k_len_i = k;
        in_valid_i = v;
        in_data_i = d;
        model_advance(st, k, v, d);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 8'd0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        start_i = 1'b0;
        in_valid_i = 1'b0;
        k_len_i = 8'd0;
        #2 rst = 1'b1;
        #1 check_reset_values();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        model_advance(1'b0, 8'd0, 1'b0, '0);
    endtask

    initial begin
        @(posedge clk);
        #1 check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        model_advance(1'b0, 8'd0, 1'b0, '0);

        // Back-to-back prefilled tile.
        step(1'b0, 8'd0, 1'b1, 32'h04030201);
        step(1'b0, 8'd0, 1'b1, 32'h14131211);
        step(1'b0, 8'd0, 1'b1, 32'h24232221);
        step(1'b0, 8'd0, 1'b1, 32'h34333231);
        step(1'b1, 8'd4, 1'b0, '0);
        idle(14);

        // Zero-length tile.
        step(1'b1, 8'd0, 1'b0, '0);
        idle(4);

        // Starvation: one vector every third cycle.
        step(1'b1, 8'd3, 1'b0, '0);
        for (int j = 0; j < 12; j++) step(1'b0, 8'd0, (j % 3) == 0, $urandom);
        idle(8);

        // FIFO full, then drain with in_valid still held.
        for (int j = 0; j < 6; j++) step(1'b0, 8'd0, 1'b1, $urandom);
        step(1'b1, 8'd4, 1'b1, $urandom);
        for (int j = 0; j < 4; j++) step(1'b0, 8'd0, 1'b1, $urandom);
        idle(10);

        // start during FEED must be ignored.
        step(1'b1, 8'd3, 1'b0, '0);
        step(1'b1, 8'd7, 1'b0, '0);
        step(1'b1, 8'd0, 1'b1, $urandom);
        idle(12);

        // Reset after two of four pops.
        idle(2);
        for (int j = 0; j < 4; j++) step(1'b0, 8'd0, 1'b1, $urandom);
        step(1'b1, 8'd4, 1'b0, '0);
        idle(2);
        do_reset();
        step(1'b1, 8'd2, 1'b0, '0);
        idle(3);
        step(1'b0, 8'd0, 1'b1, $urandom);
        step(1'b0, 8'd0, 1'b1, $urandom);
        idle(10);

        // Random traffic.
        for (int j = 0; j < 600; j++) begin
            step(($urandom % 6) == 0, 8'($urandom_range(0, 6)), ($urandom % 2) == 0, $urandom);
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter ROWS, default 4, SHALL set the number of array rows fed; lane i drives the data_in_left input of row i.
REQ-002 Parameter DEPTH, default 4, SHALL set the input FIFO depth in vectors; it SHALL be a power of two.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a tile; sampled only in IDLE.
REQ-006 k_len  input  8  number of vectors in the tile; sampled with start.
REQ-007 in_valid  input  1  in_data holds a valid activation vector.
REQ-008 in_ready  output  1  FIFO can accept a vector.
REQ-009 in_data  input  8*ROWS  vector; lane i at bits [8i+7:8i].
REQ-010 out_data  output  8*ROWS  skewed lane data to the array's left edge.
REQ-011 out_valid  output  ROWS  per-lane flag: out_data lane carries a real element.
REQ-012 pe_enable  output  1  enable for all PEs in the array.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle tile-complete pulse.

Function
REQ-015 States SHALL be IDLE, FEED, DRAIN and DONE.
REQ-016 State transitions SHALL be:
- IDLE->FEED on start with k_len!=0.
- IDLE->DONE on start with k_len==0.
- FEED->DRAIN in the cycle after the k_len-th pop.
- DRAIN->DONE after exactly ROWS DRAIN cycles.
- DONE->IDLE unconditionally.
REQ-017 start SHALL be ignored in FEED, DRAIN and DONE.
REQ-018 FIFO push: in_valid && in_ready in any state; in_ready = !full, from registered occupancy only.
REQ-019 FIFO pop: one vector per cycle in FEED when non-empty and fed count < k_len.
REQ-020 The FIFO SHALL have no fall-through: a vector pushed at cycle t is poppable no earlier than t+1.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 Fed count SHALL be 8 bits, cleared on leaving IDLE, and incremented per pop.
REQ-023 A vector popped at cycle c SHALL appear on lane i of out_data, with out_valid[i]=1, at cycle c+1+i (registered skew shift chain, lane 0 one register deep, lane i i+1 deep).
REQ-024 In FEED, a non-pop cycle SHALL inject a bubble: all-zero data and out_valid=0 propagated down the skew chain; the tile stalls without error.
REQ-025 In DRAIN, bubbles SHALL be injected every cycle so the last vector fully exits lane ROWS-1 on the final DRAIN cycle.
REQ-026 pe_enable SHALL equal (state==FEED || state==DRAIN), decoded from the state register.
REQ-027 done SHALL be high exactly in the DONE cycle; busy SHALL be low only in IDLE.
REQ-028 out_data lanes without valid data SHALL read zero so that PE MACs add nothing.
REQ-029 Vectors pushed beyond k_len SHALL remain in the FIFO for the next tile.

Reset
REQ-030 rst SHALL force, immediately and regardless of clk:
- state IDLE;
- FIFO empty, with pointers, occupancy and fed count zero;
- skew chain zero.
REQ-031 Output values while rst is high: in_ready=1, out_data=0, out_valid=0, pe_enable=0, busy=0, done=0.
REQ-032 A reset mid-FEED or mid-DRAIN SHALL discard all buffered and in-flight vectors.

Verification
REQ-033 Back-to-back: prefill 4 vectors (lanes 0x01..0x04, 0x11..0x14, 0x21..0x24, 0x31..0x34), then start with k_len=4 -> lane0 = 0x01,0x11,0x21,0x31 on consecutive cycles, and lane3 = 0x04 three cycles after lane0 = 0x01.
REQ-034 Timing for REQ-033 -> DRAIN lasts 4 cycles; done pulses one cycle after lane3 shows 0x34; pe_enable is high for every FEED and DRAIN cycle.
REQ-035 Starvation: start k_len=3 with the FIFO empty, push one vector every 3 cycles -> bubbles with out_valid=0 and zero data between elements; done after the third vector drains.
REQ-036 FIFO full: hold in_valid with no start -> in_ready drops after 4 accepts; a fifth vector is not accepted; start then pops and in_ready rises the cycle after the first pop.
REQ-037 Edge cases:
- start with k_len=0 -> DONE the next cycle, done=1 for one cycle, pe_enable never high.
- start during FEED -> ignored.
REQ-038 Reset mid-FEED after 2 of 4 pops -> all outputs at reset values immediately; the FIFO is empty; a new tile runs correctly afterward.
